// File: rtl/llvga_modal_pkg.sv
// -----------------------------------------------------------------------------
// llvga_modal_pkg
// Shared video-mode definitions for the video blocks:
//   - DEF_* : the 640x480@60 fallback timing (active/porch/synch/raw per axis)
//   - mode_legal() : sanity check applied to one axis of a mode request
// Positions on an axis run 0..raw-1. Active video occupies [0, act). Sync
// occupies [porch, synch). The check keeps those regions ordered and non-empty.
// -----------------------------------------------------------------------------
package llvga_modal_pkg;

    localparam int DEF_H_WIDTH  = 640;
    localparam int DEF_H_PORCH  = 656;
    localparam int DEF_H_SYNCH  = 752;
    localparam int DEF_H_RAW    = 800;

    localparam int DEF_V_HEIGHT = 480;
    localparam int DEF_V_PORCH  = 490;
    localparam int DEF_V_SYNCH  = 492;
    localparam int DEF_V_RAW    = 525;

    // One axis is legal when 4 < act < porch < synch < raw.
    function automatic logic mode_legal(input logic [31:0] act,
                                        input logic [31:0] porch,
                                        input logic [31:0] synch,
                                        input logic [31:0] raw);
        return (act > 32'd4) && (act < porch) && (porch < synch) && (synch < raw);
    endfunction

endpackage

// File: rtl/llvga_modal_if.sv
// -----------------------------------------------------------------------------
// llvga_modal_if
// Pixel-source handshake between a frame source and the timing generator.
//   i_rgb_pix   : {R,G,B} pixel, red in the MSBs
//   i_rgb_valid : source has a pixel available
//   o_rd        : pixel consumed this cycle
// Modport src : the pixel source (drives pixel/valid, sees o_rd)
// Modport snk : the timing generator (consumes pixel/valid, drives o_rd)
// -----------------------------------------------------------------------------
interface llvga_modal_if #(
    parameter int BPC = 8
) ();
    logic [3*BPC-1:0] i_rgb_pix;
    logic             i_rgb_valid;
    logic             o_rd;

    modport src (output i_rgb_pix, output i_rgb_valid, input  o_rd);
    modport snk (input  i_rgb_pix, input  i_rgb_valid, output o_rd);
endinterface

// File: rtl/llvga_modal_vidaxis.sv
// -----------------------------------------------------------------------------
// llvga_modal_vidaxis
// One video timing axis: a position counter that wraps after len-1, with
// region decodes for the active and sync windows.
//   i_pixclk, i_reset : clock, synchronous active-high reset (position -> 0)
//   i_en              : advance the position this cycle
//   i_len             : raw length of the axis (positions 0..len-1)
//   i_act             : active length (active while pos < act)
//   i_porch, i_synch  : sync window (porch <= pos < synch)
//   o_active, o_sync  : region decodes for the current position
//   o_last            : position is len-1 (wraps on the next enabled cycle)
//   o_act_last        : position is act-1 (last active position)
// -----------------------------------------------------------------------------
module llvga_modal_vidaxis #(
    parameter int W = 12
) (
    input  logic         i_pixclk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic [W-1:0] i_len,
    input  logic [W-1:0] i_act,
    input  logic [W-1:0] i_porch,
    input  logic [W-1:0] i_synch,
    output logic         o_active,
    output logic         o_sync,
    output logic         o_last,
    output logic         o_act_last
);

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;

    assign o_last     = (pos_q == i_len - 1'b1);
    assign o_act_last = (pos_q == i_act - 1'b1);
    assign o_active   = (pos_q < i_act);
    assign o_sync     = (pos_q >= i_porch) && (pos_q < i_synch);

    always_comb begin
        pos_d = pos_q;
        if (i_en) begin
            pos_d = o_last ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/llvga_modal.sv
// -----------------------------------------------------------------------------
// llvga_modal
// Mode-programmable VGA-style timing generator with a pixel-pull interface.
//   i_pixclk, i_reset        : pixel clock, synchronous active-high reset
//   pix (llvga_modal_if.snk) : pixel source handshake (pixel, valid, o_rd)
//   i_hm_* / i_vm_*          : requested horizontal / vertical mode
//   i_hpol, i_vpol           : sync polarity (1 = active-high pulse), live
//   o_newline, o_newframe    : single-cycle strobes after the last active pixel
//   o_hsync, o_vsync, o_de   : syncs and data enable, aligned with colour
//   o_red, o_grn, o_blu      : colour, forced to zero when o_de is low
//   o_mode_err, o_underflow  : sticky status, cleared only by reset
// The mode request is only sampled at the last pixel of a frame (and during
// reset), so a frame always runs with a single consistent timing.
// -----------------------------------------------------------------------------
module llvga_modal
    import llvga_modal_pkg::*;
#(
    parameter int BPC = 8,
    parameter int HW  = 12,
    parameter int VW  = 12
) (
    input  logic           i_pixclk,
    input  logic           i_reset,
    llvga_modal_if.snk     pix,
    input  logic [HW-1:0]  i_hm_width,
    input  logic [HW-1:0]  i_hm_porch,
    input  logic [HW-1:0]  i_hm_synch,
    input  logic [HW-1:0]  i_hm_raw,
    input  logic [VW-1:0]  i_vm_height,
    input  logic [VW-1:0]  i_vm_porch,
    input  logic [VW-1:0]  i_vm_synch,
    input  logic [VW-1:0]  i_vm_raw,
    input  logic           i_hpol,
    input  logic           i_vpol,
    output logic           o_newline,
    output logic           o_newframe,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic [BPC-1:0] o_red,
    output logic [BPC-1:0] o_grn,
    output logic [BPC-1:0] o_blu,
    output logic           o_mode_err,
    output logic           o_underflow
);

    // Shadow mode: the only timing the counters ever see.
    logic [HW-1:0] h_act_q, h_porch_q, h_synch_q, h_raw_q;
    logic [VW-1:0] v_act_q, v_porch_q, v_synch_q, v_raw_q;

    logic req_ok;
    logic eof;
    logic rd;
    logic first_q;      // suppress reads for the first frame after reset
    logic rst_bad_q;    // reset-time request was illegal; report once released

    logic h_active, h_sync, h_last, h_act_last;
    logic v_active, v_sync, v_last, v_act_last;

    logic [3*BPC-1:0] rgb_q, rgb_d;
    logic de_q, nl_q, nf_q, hs_q, vs_q, err_q, und_q;

    assign req_ok = mode_legal(32'(i_hm_width),  32'(i_hm_porch), 32'(i_hm_synch), 32'(i_hm_raw)) &&
                    mode_legal(32'(i_vm_height), 32'(i_vm_porch), 32'(i_vm_synch), 32'(i_vm_raw));

    llvga_modal_vidaxis #(.W(HW)) u_haxis (
        .i_pixclk   (i_pixclk),
        .i_reset    (i_reset),
        .i_en       (1'b1),
        .i_len      (h_raw_q),
        .i_act      (h_act_q),
        .i_porch    (h_porch_q),
        .i_synch    (h_synch_q),
        .o_active   (h_active),
        .o_sync     (h_sync),
        .o_last     (h_last),
        .o_act_last (h_act_last)
    );

    // The vertical axis steps only when the horizontal axis wraps.
    llvga_modal_vidaxis #(.W(VW)) u_vaxis (
        .i_pixclk   (i_pixclk),
        .i_reset    (i_reset),
        .i_en       (h_last),
        .i_len      (v_raw_q),
        .i_act      (v_act_q),
        .i_porch    (v_porch_q),
        .i_synch    (v_synch_q),
        .o_active   (v_active),
        .o_sync     (v_sync),
        .o_last     (v_last),
        .o_act_last (v_act_last)
    );

    assign eof = h_last && v_last;

    // Shadow capture. At end of frame both counters wrap to zero on the same
    // edge the new mode lands, so the next frame starts cleanly in that mode.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            rst_bad_q <= !req_ok;
            if (req_ok) begin
                h_act_q   <= i_hm_width;
                h_porch_q <= i_hm_porch;
                h_synch_q <= i_hm_synch;
                h_raw_q   <= i_hm_raw;
                v_act_q   <= i_vm_height;
                v_porch_q <= i_vm_porch;
                v_synch_q <= i_vm_synch;
                v_raw_q   <= i_vm_raw;
            end else begin
                h_act_q   <= HW'(DEF_H_WIDTH);
                h_porch_q <= HW'(DEF_H_PORCH);
                h_synch_q <= HW'(DEF_H_SYNCH);
                h_raw_q   <= HW'(DEF_H_RAW);
                v_act_q   <= VW'(DEF_V_HEIGHT);
                v_porch_q <= VW'(DEF_V_PORCH);
                v_synch_q <= VW'(DEF_V_SYNCH);
                v_raw_q   <= VW'(DEF_V_RAW);
            end
        end else begin
            rst_bad_q <= 1'b0;
            if (eof && req_ok) begin
                h_act_q   <= i_hm_width;
                h_porch_q <= i_hm_porch;
                h_synch_q <= i_hm_synch;
                h_raw_q   <= i_hm_raw;
                v_act_q   <= i_vm_height;
                v_porch_q <= i_vm_porch;
                v_synch_q <= i_vm_synch;
                v_raw_q   <= i_vm_raw;
            end
        end
    end

    // Read strobe is a pure decode of the counter state, so the pixel sampled
    // on this edge belongs to exactly the position the counters show.
    assign rd    = h_active && v_active && !first_q;
    assign pix.o_rd = rd;

    // A missing pixel on a read cycle is shown as black.
    always_comb begin
        rgb_d = '0;
        if (rd && pix.i_rgb_valid) begin
            rgb_d = pix.i_rgb_pix;
        end
    end

    // Output stage: everything is delayed by one cycle together so that
    // colour, data enable and both syncs stay aligned.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            first_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            nl_q    <= 1'b0;
            nf_q    <= 1'b0;
            hs_q    <= !i_hpol;
            vs_q    <= !i_vpol;
            err_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            if (eof) begin
                first_q <= 1'b0;
            end
            de_q  <= rd;
            rgb_q <= rgb_d;
            nl_q  <= h_act_last;
            nf_q  <= h_act_last && v_act_last;
            hs_q  <= h_sync ? i_hpol : !i_hpol;
            vs_q  <= v_sync ? i_vpol : !i_vpol;
            err_q <= err_q || rst_bad_q || (eof && !req_ok);
            und_q <= und_q || (rd && !pix.i_rgb_valid);
        end
    end

    assign o_de        = de_q;
    assign o_red       = rgb_q[3*BPC-1:2*BPC];
    assign o_grn       = rgb_q[2*BPC-1:BPC];
    assign o_blu       = rgb_q[BPC-1:0];
    assign o_newline   = nl_q;
    assign o_newframe  = nf_q;
    assign o_hsync     = hs_q;
    assign o_vsync     = vs_q;
    assign o_mode_err  = err_q;
    assign o_underflow = und_q;

endmodule

// File: tb/tb_llvga_modal.sv
// -----------------------------------------------------------------------------
// tb_llvga_modal
// Self-checking bench for llvga_modal: a frame-level reference model checked
// every cycle, plus per-frame counts against hand-computed numbers for a small
// 16/18/20/24 x 12/13/15/16 mode (384 cycles per frame).
// -----------------------------------------------------------------------------
module tb_llvga_modal;

    localparam int FRAME = 24 * 16;
    localparam int DEF[2][4] = '{'{640, 656, 752, 800}, '{480, 490, 492, 525}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] hm_w = 12'd16, hm_p = 12'd18, hm_s = 12'd20, hm_r = 12'd24;
    logic [11:0] vm_h = 12'd12, vm_p = 12'd13, vm_s = 12'd15, vm_r = 12'd16;
    logic hpol = 1'b1, vpol = 1'b1;
    logic o_newline, o_newframe, o_hsync, o_vsync, o_de, o_mode_err, o_underflow;
    logic [7:0] o_red, o_grn, o_blu;

    int total = 0;
    int bad = 0;
    int pos = 0;
    bit rnd_valid = 1'b0;

    llvga_modal_if #(.BPC(8)) pif ();

    llvga_modal #(.BPC(8), .HW(12), .VW(12)) dut (
        .i_pixclk    (clk),
        .i_reset     (rst),
        .pix         (pif),
        .i_hm_width  (hm_w),
        .i_hm_porch  (hm_p),
        .i_hm_synch  (hm_s),
        .i_hm_raw    (hm_r),
        .i_vm_height (vm_h),
        .i_vm_porch  (vm_p),
        .i_vm_synch  (vm_s),
        .i_vm_raw    (vm_r),
        .i_hpol      (hpol),
        .i_vpol      (vpol),
        .o_newline   (o_newline),
        .o_newframe  (o_newframe),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .o_red       (o_red),
        .o_grn       (o_grn),
        .o_blu       (o_blu),
        .o_mode_err  (o_mode_err),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode table [axis][act, porch, synch, raw]; axis 0 = horizontal.
    int m_mode[2][4];
    int m_req[2][4];
    int m_h = 0, m_v = 0;
    bit m_first = 1'b1, m_bad = 1'b0, m_live = 1'b0;
    logic e_de, e_nl, e_nf, e_hs, e_vs, e_err, e_und;
    logic [23:0] e_rgb;

    function automatic bit axis_ok(input int a, input int p, input int s, input int r);
        return (a > 4) && (a < p) && (p < s) && (s < r);
    endfunction

    always @(posedge clk) begin
        bit ok;
        bit rd_m;
        bit eof;
        m_req[0][0] = int'(hm_w); m_req[0][1] = int'(hm_p);
        m_req[0][2] = int'(hm_s); m_req[0][3] = int'(hm_r);
        m_req[1][0] = int'(vm_h); m_req[1][1] = int'(vm_p);
        m_req[1][2] = int'(vm_s); m_req[1][3] = int'(vm_r);
        ok = axis_ok(m_req[0][0], m_req[0][1], m_req[0][2], m_req[0][3]) &&
             axis_ok(m_req[1][0], m_req[1][1], m_req[1][2], m_req[1][3]);
        if (rst) begin
            if (ok) m_mode = m_req;
            else    m_mode = DEF;
            m_bad = !ok; m_h = 0; m_v = 0; m_first = 1'b1; m_live = 1'b1;
            e_de = 1'b0; e_rgb = 24'd0; e_nl = 1'b0; e_nf = 1'b0;
            e_hs = !hpol; e_vs = !vpol; e_err = 1'b0; e_und = 1'b0;
        end else if (m_live) begin
            rd_m  = (m_h < m_mode[0][0]) && (m_v < m_mode[1][0]) && !m_first;
            e_de  = rd_m;
            e_rgb = (rd_m && pif.i_rgb_valid) ? pif.i_rgb_pix : 24'd0;
            e_hs  = (m_h >= m_mode[0][1] && m_h < m_mode[0][2]) ? hpol : !hpol;
            e_vs  = (m_v >= m_mode[1][1] && m_v < m_mode[1][2]) ? vpol : !vpol;
            e_nl  = (m_h == m_mode[0][0] - 1);
            e_nf  = e_nl && (m_v == m_mode[1][0] - 1);
            if (rd_m && !pif.i_rgb_valid) e_und = 1'b1;
            if (m_bad) e_err = 1'b1;
            m_bad = 1'b0;
            eof = (m_h == m_mode[0][3] - 1) && (m_v == m_mode[1][3] - 1);
            if (m_h == m_mode[0][3] - 1) begin
                m_h = 0;
                m_v = (m_v == m_mode[1][3] - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            if (eof) begin
                if (ok) m_mode = m_req;
                else    e_err = 1'b1;
                m_first = 1'b0;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic exp_rd;
        if (m_live) begin
            exp_rd = (m_h < m_mode[0][0]) && (m_v < m_mode[1][0]) && !m_first;
            chk("cycle",
                {pif.o_rd, o_de, o_newline, o_newframe, o_hsync, o_vsync, o_mode_err, o_underflow,
                 o_red, o_grn, o_blu},
                {exp_rd, e_de, e_nl, e_nf, e_hs, e_vs, e_err, e_und, e_rgb});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        pos++;
        pif.i_rgb_pix = 24'($urandom);
        if (rnd_valid) pif.i_rgb_valid = ($urandom_range(0, 7) != 0);
    endtask

    task automatic run(input int n, output int c_rd, output int c_de, output int c_hs,
                       output int c_nl, output int c_nf);
        c_rd = 0; c_de = 0; c_hs = 0; c_nl = 0; c_nf = 0;
        for (int i = 0; i < n; i++) begin
            c_rd += int'(pif.o_rd);
            c_de += int'(o_de);
            c_hs += int'(o_hsync == hpol);
            c_nl += int'(o_newline);
            c_nf += int'(o_newframe);
            step();
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_flags"}, 32'({pif.o_rd, o_de, o_newline, o_newframe, o_mode_err, o_underflow}), 32'd0);
        chk({name, "_rgb"}, 32'({o_red, o_grn, o_blu}), 32'd0);
        chk({name, "_sync"}, 32'({o_hsync, o_vsync}), 32'({~hpol, ~vpol}));
    endtask

    initial begin
        int c_rd, c_de, c_hs, c_nl, c_nf, a_rd, a_de, a_hs, a_nl, a_nf;
        bit found;
        pif.i_rgb_pix   = 24'h0;
        pif.i_rgb_valid = 1'b1;

        // Phase 1: reset, suppressed first frame, full second frame.
        rst = 1'b1;
        repeat (3) step();
        chk_reset_outs("reset");
        rst = 1'b0; pos = 0;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("f1_rd", 32'(c_rd), 32'd0);
        chk("f1_nl", 32'(c_nl), 32'd16);
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("f2_rd", 32'(c_rd), 32'd192);
        chk("f2_de", 32'(c_de), 32'd192);
        chk("f2_hs_active", 32'(c_hs), 32'd32);
        chk("f2_nl", 32'(c_nl), 32'd16);
        chk("f2_nf", 32'(c_nf), 32'd1);
        $display("phase 1: frame1 rd=0 expected, frame2 rd=%0d hs=%0d", c_rd, c_hs);

        // Phase 2: negative hsync polarity.
        hpol = 1'b0;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("pol0_hs_low", 32'(c_hs), 32'd32);
        chk("pol0_de", 32'(c_de), 32'd192);
        $display("phase 2: hpol=0 low cycles=%0d de=%0d", c_hs, c_de);
        hpol = 1'b1;

        // Phase 3: width changed to 8 in the middle of a frame.
        run(FRAME / 2, a_rd, a_de, a_hs, a_nl, a_nf);
        hm_w = 12'd8;
        run(FRAME / 2, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("midchg_cur_rd", 32'(a_rd + c_rd), 32'd192);
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("midchg_next_rd", 32'(c_rd), 32'd96);
        chk("midchg_next_nl", 32'(c_nl), 32'd16);
        $display("phase 3: width 8 frame rd=%0d", c_rd);

        // Phase 4: back to 16, then an illegal request.
        hm_w = 12'd16;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("restore_rd", 32'(c_rd), 32'd96);
        chk("err_clear", 32'(o_mode_err), 32'd0);
        hm_w = 12'd20; hm_p = 12'd18;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("illegal_rd", 32'(c_rd), 32'd192);
        chk("err_set", 32'(o_mode_err), 32'd1);
        hm_w = 12'd16;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("kept_rd", 32'(c_rd), 32'd192);
        chk("err_sticky", 32'(o_mode_err), 32'd1);
        $display("phase 4: illegal request rejected, rd=%0d err=%0b", c_rd, o_mode_err);

        // Phase 5: one missing pixel, then a frame of random validity.
        chk("ufl_clear", 32'(o_underflow), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (pif.o_rd) found = 1'b1;
            else step();
        end
        chk("ufl_find_rd", 32'(found), 32'd1);
        pif.i_rgb_valid = 1'b0;
        step();
        pif.i_rgb_valid = 1'b1;
        chk("ufl_de", 32'(o_de), 32'd1);
        chk("ufl_black", 32'({o_red, o_grn, o_blu}), 32'd0);
        chk("ufl_flag", 32'(o_underflow), 32'd1);
        rnd_valid = 1'b1;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        rnd_valid = 1'b0;
        pif.i_rgb_valid = 1'b1;
        chk("ufl_sticky", 32'(o_underflow), 32'd1);
        $display("phase 5: underflow=%0b after random-valid frame", o_underflow);

        // Phase 6: reset at vpos=5.
        while ((pos % FRAME) != 5 * 24 + 3) step();
        rst = 1'b1;
        step();
        chk_reset_outs("midreset");
        rst = 1'b0; pos = 0;
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("post_rst_f1_rd", 32'(c_rd), 32'd0);
        run(FRAME, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("post_rst_f2_rd", 32'(c_rd), 32'd192);
        $display("phase 6: after mid-frame reset frame2 rd=%0d", c_rd);

        // Phase 7: illegal request held through reset falls back to defaults.
        hm_w = 12'd20; hm_p = 12'd18;
        rst = 1'b1;
        step(); step();
        chk("rst_illegal_err_in_reset", 32'(o_mode_err), 32'd0);
        rst = 1'b0; pos = 0;
        step(); step();
        chk("rst_illegal_err", 32'(o_mode_err), 32'd1);
        run(40, c_rd, c_de, c_hs, c_nl, c_nf);
        chk("default_first_rd", 32'(c_rd), 32'd0);
        $display("phase 7: illegal reset request err=%0b", o_mode_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
